mdio_peripheral: RTL

MDIO_PERIPHERAL -- requirements
Module: mdio_peripheral

---
 rtl/mdio_pkg.sv | 32 +++
 rtl/mdio_regfile.sv | 29 ++
 rtl/mdio_peripheral.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO management peripheral.
// Holds the FSM state enumeration, frame field codes and the header layout.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    TA,
    WDATA,
    RDATA,
    DRAIN
  } mdio_state_e;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST_CODE  = 2'b01;

  localparam int HDR_BITS  = 14;
  localparam int DATA_BITS = 16;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] op;
    logic [4:0] phyad;
    logic [4:0] regad;
  } mdio_hdr_t;

  function automatic logic hdr_well_formed(input mdio_hdr_t h);
    return (h.st == ST_CODE) && ((h.op == OP_WRITE) || (h.op == OP_READ));
  endfunction

endpackage

// File: rtl/mdio_regfile.sv
// 32 x 16-bit register file behind the MDIO peripheral.
// One synchronous write port, one asynchronous read port, asynchronous reset.
module mdio_regfile
  import mdio_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [4:0]           raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [32];

  // NOTE: the array is reset like ordinary flops because registers must read 0 after reset;
  // this rules out a RAM macro, which is acceptable at 32 entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mdio_peripheral.sv
// MDIO (clause-22 style) management peripheral: decodes write/read frames on MDC ticks.
// Optional build macro MDIO_PHYAD_FILTER_EN drains frames addressed to another PHYAD.
module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_IN,
  output logic        MDIO_IN_OE,
  output logic        WR_STB,
  output logic [4:0]  REG_ADDR,
  output logic [15:0] WR_DATA,
  output logic        RD_DONE,
  output logic        FRAME_ERR
);

  mdio_state_e state, state_d;

  logic        mdc_q;
  logic        tick;
  logic [4:0]  cnt, cnt_d;
  logic [12:0] hdr_sr, hdr_sr_d;
  logic [14:0] wr_sr, wr_sr_d;
  logic        is_read, is_read_d;
  logic [4:0]  regad, regad_d;
  logic        mdio_in_d, mdio_in_oe_d, wr_stb_d, rd_done_d, frame_err_d;
  logic [4:0]  reg_addr_d;
  logic [15:0] wr_data_d;
  logic        we;
  logic [15:0] wr_word;
  logic [15:0] rd_data;
  logic [3:0]  rd_idx;
  logic        phy_ok;
  mdio_hdr_t   hdr_full;

  assign tick     = MDC & ~mdc_q;
  assign hdr_full = {hdr_sr, MDIO_OUT};
  assign wr_word  = {wr_sr, MDIO_OUT};
  assign rd_idx   = cnt[3:0] - 4'd1;

`ifdef MDIO_PHYAD_FILTER_EN
  assign phy_ok = (hdr_full.phyad == PHY_ADDR);
`else
  assign phy_ok = 1'b1;
  logic unused_phy;
  assign unused_phy = ^{hdr_full.phyad, PHY_ADDR};
`endif

  mdio_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (regad),
    .wdata (wr_word),
    .raddr (regad),
    .rdata (rd_data)
  );

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdc_q      <= 1'b0;
      cnt        <= '0;
      hdr_sr     <= '0;
      wr_sr      <= '0;
      is_read    <= 1'b0;
      regad      <= '0;
      MDIO_IN    <= 1'b0;
      MDIO_IN_OE <= 1'b0;
      WR_STB     <= 1'b0;
      REG_ADDR   <= '0;
      WR_DATA    <= '0;
      RD_DONE    <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      mdc_q      <= MDC;
      cnt        <= cnt_d;
      hdr_sr     <= hdr_sr_d;
      wr_sr      <= wr_sr_d;
      is_read    <= is_read_d;
      regad      <= regad_d;
      MDIO_IN    <= mdio_in_d;
      MDIO_IN_OE <= mdio_in_oe_d;
      WR_STB     <= wr_stb_d;
      REG_ADDR   <= reg_addr_d;
      WR_DATA    <= wr_data_d;
      RD_DONE    <= rd_done_d;
      FRAME_ERR  <= frame_err_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state;
    cnt_d        = cnt;
    hdr_sr_d     = hdr_sr;
    wr_sr_d      = wr_sr;
    is_read_d    = is_read;
    regad_d      = regad;
    mdio_in_d    = MDIO_IN;
    mdio_in_oe_d = MDIO_IN_OE;
    reg_addr_d   = REG_ADDR;
    wr_data_d    = WR_DATA;
    wr_stb_d     = 1'b0;
    rd_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    we           = 1'b0;

    case (state)
      IDLE: begin
        if (tick && MDIO_OE) begin
          hdr_sr_d = {hdr_sr[11:0], MDIO_OUT};
          cnt_d    = 5'(HDR_BITS - 2);
          state_d  = HDR;
        end
      end

      HDR: begin
        if (!MDIO_OE) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (tick) begin
          hdr_sr_d = {hdr_sr[11:0], MDIO_OUT};
          if (cnt == 5'd0) begin
            if (!hdr_well_formed(hdr_full)) begin
              frame_err_d = 1'b1;
              state_d     = DRAIN;
            end else if (!phy_ok) begin
              state_d = DRAIN;
            end else begin
              is_read_d  = (hdr_full.op == OP_READ);
              regad_d    = hdr_full.regad;
              reg_addr_d = hdr_full.regad;
              cnt_d      = 5'd1;
              state_d    = TA;
            end
          end else begin
            cnt_d = cnt - 5'd1;
          end
        end
      end

      TA: begin
        if (tick) begin
          if (cnt != 5'd0) begin
            cnt_d = cnt - 5'd1;
          end else if (is_read) begin
            // Second turnaround bit: the peripheral takes the line and drives 0.
            mdio_in_oe_d = 1'b1;
            mdio_in_d    = 1'b0;
            cnt_d        = 5'(DATA_BITS);
            state_d      = RDATA;
          end else begin
            cnt_d   = 5'(DATA_BITS - 1);
            state_d = WDATA;
          end
        end
      end

      WDATA: begin
        if (!MDIO_OE) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (tick) begin
          wr_sr_d = {wr_sr[13:0], MDIO_OUT};
          if (cnt == 5'd0) begin
            we         = 1'b1;
            wr_data_d  = wr_word;
            reg_addr_d = regad;
            wr_stb_d   = 1'b1;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt - 5'd1;
          end
        end
      end

      RDATA: begin
        if (tick) begin
          if (cnt == 5'd0) begin
            mdio_in_oe_d = 1'b0;
            mdio_in_d    = 1'b0;
            rd_done_d    = 1'b1;
            state_d      = IDLE;
          end else begin
            mdio_in_d = rd_data[rd_idx];
            cnt_d     = cnt - 5'd1;
          end
        end
      end

      DRAIN: begin
        if (!MDIO_OE) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
